// File: rtl/spi_eeprom_pkg.sv
// Shared types and constants for the two-port SPI EEPROM read arbiter.
package spi_eeprom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DESEL
    } state_t;

    localparam logic [7:0] OPC_READ   = 8'h03;
    localparam int         ADDR_W     = 16;
    localparam int         DATA_W     = 8;
    localparam int         FRAME_BITS = 32;

    // Opcode, address, then a zero byte clocked out while the EEPROM returns data.
    function automatic logic [FRAME_BITS-1:0] read_frame(input logic [ADDR_W-1:0] addr);
        return {OPC_READ, addr, 8'h00};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: clocks out one 32-bit frame per start pulse and
// collects the trailing data byte from miso.
module spi_shift_engine
    import spi_eeprom_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  miso,
    output logic                  done,
    output logic                  spi_clk,
    output logic                  mosi,
    output logic [DATA_W-1:0]     rx_data
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST  = 6'(FRAME_BITS - 1);
    localparam logic [5:0] RX_FIRST  = 6'(FRAME_BITS - DATA_W);

    logic                  active;
    logic                  phase_high;
    logic [7:0]            half_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  half_end;
    logic                  last_bit;

    assign half_end = (half_cnt == HALF_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign done     = active && phase_high && half_end && last_bit;
    assign spi_clk  = active && phase_high;
    assign mosi     = active && shreg[FRAME_BITS-1];

    // Each bit is a low half then a high half; mosi moves only when the low half
    // begins, and miso is taken on the edge that raises spi_clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= 1'b0;
            phase_high <= 1'b0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
        end else if (start) begin
            active     <= 1'b1;
            phase_high <= 1'b0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= frame;
        end else if (active) begin
            if (!half_end) begin
                half_cnt <= half_cnt + 8'd1;
            end else begin
                half_cnt <= '0;
                if (!phase_high) begin
                    phase_high <= 1'b1;
                    if (bit_cnt >= RX_FIRST) begin
                        rx_data <= {rx_data[DATA_W-2:0], miso};
                    end
                end else begin
                    phase_high <= 1'b0;
                    if (last_bit) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_eeprom_arbiter.sv
// Round-robin arbiter giving two requesters single-byte reads from one
// SPI EEPROM (READ opcode 0x03, 16-bit address).
module spi_eeprom_arbiter
    import spi_eeprom_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int DESEL_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spi_clk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss
);

    localparam logic [15:0] EDGE_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] DESEL_LAST = 16'(DESEL_CYC - 1);

    state_t              state;
    state_t              state_next;
    logic [15:0]         wait_cnt;
    logic                granted;
    logic                grant_sel;
    logic                rr_pref;
    logic [ADDR_W-1:0]   addr_reg;
    logic                start;
    logic                done;
    logic [DATA_W-1:0]   rx_data;

    // On a tie the pointer picks whoever was not served last; a lone request always wins.
    assign grant_sel = (req0 && req1) ? rr_pref : req1;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE:  if (req0 || req1) state_next = SETUP;
            SETUP: if (wait_cnt == EDGE_LAST) begin
                       state_next = SHIFT;
                       start      = 1'b1;
                   end
            SHIFT: if (done) state_next = HOLD;
            HOLD:  if (wait_cnt == EDGE_LAST) state_next = DESEL;
            DESEL: if (wait_cnt == DESEL_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dwell counter for SETUP, HOLD and DESEL; restarts from zero on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            granted  <= 1'b0;
            rr_pref  <= 1'b0;
            addr_reg <= '0;
        end else if (state == IDLE && (req0 || req1)) begin
            granted  <= grant_sel;
            rr_pref  <= ~grant_sel;
            addr_reg <= grant_sel ? addr1 : addr0;
        end
    end

    // The response is launched on the HOLD->DESEL edge so it lands in the first DESEL cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            if (state == HOLD && state_next == DESEL) begin
                rsp_valid0 <= ~granted;
                rsp_valid1 <= granted;
                rsp_data   <= rx_data;
            end
        end
    end

    assign busy = (state != IDLE);
    assign ss   = !(state == SETUP || state == SHIFT || state == HOLD);

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .frame   (read_frame(addr_reg)),
        .miso    (miso),
        .done    (done),
        .spi_clk (spi_clk),
        .mosi    (mosi),
        .rx_data (rx_data)
    );

endmodule
